// File: rtl/branch_ctrl.sv
// Branch sequencing controller: 2-bit BHT prediction at IF, EX-stage resolve and
// redirect, load-use stall arbitration, wrong-path shadow window and branch statistics.
module branch_ctrl #(
  parameter int BHT_ENTRIES   = 16,
  parameter int SHADOW_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  input  logic        ex_valid,
  input  logic [4:0]  ex_brop,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic        ex_pred_taken,
  input  logic        hazard_stall,
  output logic [1:0]  pc_sel,
  output logic        stall_if,
  output logic        stall_id,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispredict_cnt
);

  localparam int IDX = (BHT_ENTRIES > 1) ? $clog2(BHT_ENTRIES) : 1;

  typedef enum logic {RUN = 1'b0, SHADOW = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [2:0]      shadow_q, shadow_d;
  logic [1:0]      bht_q [BHT_ENTRIES];
  logic [IDX-1:0]  if_idx, ex_idx;
  logic            is_cond, is_jump, resolve, mispredict;
  logic [31:0]     branch_cnt_q, mispredict_cnt_q;
  logic            unused_bits;

  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic up);
    if (up) return (ctr == 2'b11) ? ctr : ctr + 2'd1;
    else    return (ctr == 2'b00) ? ctr : ctr - 2'd1;
  endfunction

  assign if_idx     = if_pc[IDX+1:2];
  assign ex_idx     = ex_pc[IDX+1:2];
  assign pred_taken = bht_q[if_idx][1];

  assign is_jump    = ex_brop[4];
  assign is_cond    = (ex_brop[4:3] == 2'b01);
  // Outcomes are only trusted outside the wrong-path shadow window.
  assign resolve    = (state_q == RUN) && ex_valid && (ex_brop[4:3] != 2'b00);
  assign mispredict = resolve && ((is_cond && (ex_taken != ex_pred_taken)) ||
                                  (is_jump && !ex_pred_taken));

  assign unused_bits = ^{if_pc[31:IDX+2], if_pc[1:0], ex_pc[31:IDX+2], ex_pc[1:0], ex_brop[2:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      shadow_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    pc_sel     = 2'b00;
    stall_if   = 1'b0;
    stall_id   = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    case (state_q)
      RUN: begin
        if (mispredict) begin
          state_d  = SHADOW;
          shadow_d = 3'(SHADOW_CYCLES);
        end
      end
      SHADOW: begin
        if (shadow_q <= 3'd1) begin
          state_d  = RUN;
          shadow_d = 3'd0;
        end else begin
          shadow_d = shadow_q - 3'd1;
        end
      end
      default: state_d = RUN;
    endcase
    // A redirect squashes the stalled instruction anyway, so it wins over load-use.
    if (mispredict) begin
      pc_sel     = ex_taken ? 2'b01 : 2'b10;
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
    end else if (hazard_stall) begin
      stall_if   = 1'b1;
      stall_id   = 1'b1;
      flush_idex = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
    end else if (resolve && is_cond) begin
      bht_q[ex_idx] <= sat_update(bht_q[ex_idx], ex_taken);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt_q     <= 32'd0;
      mispredict_cnt_q <= 32'd0;
    end else begin
      if (resolve)    branch_cnt_q     <= branch_cnt_q + 32'd1;
      if (mispredict) mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
    end
  end

  assign branch_cnt     = branch_cnt_q;
  assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: behavioural model checked every cycle on the
// falling edge, plus literal expectations at the key points of each scenario.
module tb_branch_ctrl;

  localparam int SH  = 2;
  localparam int ENT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] if_pc = 32'h40;
  logic        pred_taken;
  logic        ex_valid = 1'b0;
  logic [4:0]  ex_brop = 5'd0;
  logic [31:0] ex_pc = 32'd0;
  logic        ex_taken = 1'b0;
  logic        ex_pred_taken = 1'b0;
  logic        hazard_stall = 1'b0;
  logic [1:0]  pc_sel;
  logic        stall_if, stall_id, flush_ifid, flush_idex;
  logic [31:0] branch_cnt, mispredict_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  branch_ctrl #(.BHT_ENTRIES(ENT), .SHADOW_CYCLES(SH)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(pred_taken),
    .ex_valid(ex_valid), .ex_brop(ex_brop), .ex_pc(ex_pc), .ex_taken(ex_taken),
    .ex_pred_taken(ex_pred_taken), .hazard_stall(hazard_stall), .pc_sel(pc_sel),
    .stall_if(stall_if), .stall_id(stall_id), .flush_ifid(flush_ifid),
    .flush_idex(flush_idex), .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: counter values, remaining wrong-path cycles, statistics.
  int          m_bht [ENT];
  int          m_shadow;
  logic [31:0] m_br, m_mis;

  always @(negedge clk) begin : model_cmp
    logic is_br, is_cond, is_jump, mis;
    int   ei;
    if (rst) begin
      for (int i = 0; i < ENT; i++) m_bht[i] = 1;
      m_shadow = 0;
      m_br     = 0;
      m_mis    = 0;
    end
    is_br   = ex_valid && (ex_brop[4:3] != 2'b00);
    is_cond = (ex_brop[4:3] == 2'b01);
    is_jump = ex_brop[4];
    mis = (m_shadow == 0) && is_br &&
          ((is_cond && (ex_taken != ex_pred_taken)) || (is_jump && !ex_pred_taken));
    chk("m_pred_taken", pred_taken, (m_bht[(if_pc / 4) % ENT] >= 2) ? 1 : 0);
    chk("m_pc_sel", pc_sel, mis ? (ex_taken ? 1 : 2) : 0);
    chk("m_flush_ifid", flush_ifid, mis);
    chk("m_flush_idex", flush_idex, mis || hazard_stall);
    chk("m_stall_if", stall_if, !mis && hazard_stall);
    chk("m_stall_id", stall_id, !mis && hazard_stall);
    chk("m_branch_cnt", branch_cnt, m_br);
    chk("m_mispredict_cnt", mispredict_cnt, m_mis);
    if (!rst) begin
      if (m_shadow > 0) begin
        m_shadow--;
      end else if (is_br) begin
        m_br = m_br + 1;
        if (is_cond) begin
          ei = (ex_pc / 4) % ENT;
          if (ex_taken) m_bht[ei] = (m_bht[ei] < 3) ? m_bht[ei] + 1 : 3;
          else          m_bht[ei] = (m_bht[ei] > 0) ? m_bht[ei] - 1 : 0;
        end
        if (mis) begin
          m_mis    = m_mis + 1;
          m_shadow = SH;
        end
      end
    end
  end

  task automatic apply(input logic v, input logic [4:0] op, input logic [31:0] pc,
                       input logic tk, input logic pt, input logic hz, input logic [31:0] ipc);
    @(posedge clk); #1;
    ex_valid = v; ex_brop = op; ex_pc = pc; ex_taken = tk;
    ex_pred_taken = pt; hazard_stall = hz; if_pc = ipc;
    @(negedge clk); #1;
  endtask

  task automatic idle(input logic [31:0] ipc);
    apply(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, ipc);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_pred_taken", pred_taken, 0);
    chk("rst_branch_cnt", branch_cnt, 0);
    chk("rst_pc_sel", pc_sel, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(32'h40);

    // Mispredicted taken conditional at 0x40
    apply(1, 5'b01000, 32'h40, 1, 0, 0, 32'h40);
    chk("redir_pc_sel", pc_sel, 1);
    chk("redir_flush_ifid", flush_ifid, 1);
    chk("redir_flush_idex", flush_idex, 1);
    // Two shadow cycles ignore a mispredicting branch
    apply(1, 5'b01000, 32'h84, 1, 0, 0, 32'h40);
    chk("bht_upd_pred", pred_taken, 1);
    chk("cnt_after_redir_br", branch_cnt, 1);
    chk("cnt_after_redir_mis", mispredict_cnt, 1);
    chk("shadow1_pc_sel", pc_sel, 0);
    apply(1, 5'b01000, 32'h84, 1, 0, 0, 32'h40);
    chk("shadow2_pc_sel", pc_sel, 0);
    chk("shadow2_flush_ifid", flush_ifid, 0);
    apply(1, 5'b01000, 32'h84, 1, 0, 0, 32'h84);
    chk("shadow_exit_pc_sel", pc_sel, 1);
    chk("shadow_exit_br_cnt", branch_cnt, 1);

    // Load-use stall honoured during shadow
    apply(0, 5'd0, 32'd0, 0, 0, 1, 32'h84);
    chk("hz_stall_if", stall_if, 1);
    chk("hz_stall_id", stall_id, 1);
    chk("hz_flush_idex", flush_idex, 1);
    chk("hz_flush_ifid", flush_ifid, 0);
    chk("hz_pc_sel", pc_sel, 0);
    idle(32'h84);

    // Redirect overrides a coincident load-use stall (not-taken recovery)
    apply(1, 5'b01000, 32'h88, 0, 1, 1, 32'h88);
    chk("hzmis_pc_sel", pc_sel, 2);
    chk("hzmis_stall_if", stall_if, 0);
    chk("hzmis_stall_id", stall_id, 0);
    chk("hzmis_flush_ifid", flush_ifid, 1);
    chk("hzmis_flush_idex", flush_idex, 1);
    idle(32'h88);
    idle(32'h88);
    chk("cnt_mis_3", mispredict_cnt, 3);

    // Jump predicted not-taken redirects and leaves the BHT alone
    apply(1, 5'b10000, 32'h8C, 1, 0, 0, 32'h8C);
    chk("jump_pc_sel", pc_sel, 1);
    idle(32'h8C);
    chk("jump_bht_pred", pred_taken, 0);
    chk("jump_br_cnt", branch_cnt, 4);
    idle(32'h8C);

    // Saturation at 0xD0: same-cycle read returns the old counter
    apply(1, 5'b01000, 32'hD0, 1, 1, 0, 32'hD0);
    chk("rw_old_pred", pred_taken, 0);
    chk("sat_no_redir", pc_sel, 0);
    for (int k = 0; k < 3; k++) apply(1, 5'b01000, 32'hD0, 1, 1, 0, 32'hD0);
    idle(32'hD0);
    chk("sat_pred", pred_taken, 1);
    apply(1, 5'b01000, 32'hD0, 0, 0, 0, 32'hD0);
    idle(32'hD0);
    chk("sat_dec_pred", pred_taken, 1);
    apply(1, 5'b01000, 32'hD0, 0, 0, 0, 32'hD0);
    idle(32'hD0);
    chk("sat_dec2_pred", pred_taken, 0);
    chk("sat_br_cnt", branch_cnt, 10);

    // Reset asserted mid-shadow
    apply(1, 5'b01000, 32'h90, 1, 0, 0, 32'h40);
    chk("pre_rst_pc_sel", pc_sel, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    ex_valid = 0; ex_brop = 0; ex_taken = 0; ex_pred_taken = 0; hazard_stall = 0;
    if_pc = 32'h40;
    @(negedge clk); #1;
    chk("midrst_br_cnt", branch_cnt, 0);
    chk("midrst_mis_cnt", mispredict_cnt, 0);
    chk("midrst_pred", pred_taken, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    apply(1, 5'b01000, 32'h40, 1, 0, 0, 32'h40);
    chk("postrst_redir", pc_sel, 1);
    idle(32'h40);
    chk("postrst_mis_cnt", mispredict_cnt, 1);
    idle(32'h40);
    idle(32'h40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
